// File: rtl/sprite_pkg.sv
// Shared definitions for the sprite draw engine: screen geometry, coordinate
// widths, draw modes and engine state encoding.
package sprite_pkg;
    localparam int SCREEN_W  = 320;
    localparam int SCREEN_H  = 240;
    localparam int X_W       = 9;
    localparam int Y_W       = 8;
    localparam int BG_ADDR_W = 17;

    typedef enum logic { MODE_BG, MODE_CHAR } draw_mode_t;

    typedef enum logic [1:0] { S_IDLE, S_SCAN, S_FLUSH, S_DONE } eng_state_t;
endpackage

// File: rtl/pixel_scan_counter.sv
// Raster col/row counter over a SPRITE_W x SPRITE_H box; col wraps into row.
module pixel_scan_counter #(
    parameter int SPRITE_W = 8,
    parameter int SPRITE_H = 8,
    localparam int CW = $clog2(SPRITE_W),
    localparam int RW = $clog2(SPRITE_H)
) (
    input  logic          clock,
    input  logic          resetn,
    input  logic          clear,
    input  logic          enable,
    output logic [CW-1:0] col,
    output logic [RW-1:0] row,
    output logic          last
);
    always_ff @(posedge clock) begin
        if (!resetn || clear) begin
            col <= '0;
            row <= '0;
        end else if (enable) begin
            col <= col + CW'(1);
            if (col == CW'(SPRITE_W - 1))
                row <= row + RW'(1);
        end
    end

    assign last = (col == CW'(SPRITE_W - 1)) && (row == RW'(SPRITE_H - 1));
endmodule

// File: rtl/sprite_draw_engine.sv
// Scans a sprite-sized box, fetches background or sprite ROM colour per pixel
// and emits clipped VGA plot writes, then pulses doneBG/doneChar.
module sprite_draw_engine
    import sprite_pkg::*;
#(
    parameter int SPRITE_W = 8,
    parameter int SPRITE_H = 8,
    parameter int COLOUR_W = 3,
    parameter logic [COLOUR_W-1:0] TRANSPARENT = '0,
    localparam int CW   = $clog2(SPRITE_W),
    localparam int RW   = $clog2(SPRITE_H),
    localparam int SA_W = CW + RW
) (
    input  logic                 clock,
    input  logic                 resetn,
    input  logic                 drawBG,
    input  logic                 drawChar,
    input  logic [X_W-1:0]       xIn,
    input  logic [Y_W-1:0]       yIn,
    output logic [BG_ADDR_W-1:0] bg_addr,
    input  logic [COLOUR_W-1:0]  bg_data,
    output logic [SA_W-1:0]      spr_addr,
    input  logic [COLOUR_W-1:0]  spr_data,
    output logic [X_W-1:0]       vga_x,
    output logic [Y_W-1:0]       vga_y,
    output logic [COLOUR_W-1:0]  vga_colour,
    output logic                 vga_plot,
    output logic                 doneBG,
    output logic                 doneChar,
    output logic                 busy
);
    eng_state_t      state, next_state;
    draw_mode_t      mode;
    logic [X_W-1:0]  origin_x;
    logic [Y_W-1:0]  origin_y;
    logic [CW-1:0]   col;
    logic [RW-1:0]   row;
    logic            last;
    logic            start, scan;
    logic [X_W:0]    sx_p0;
    logic [Y_W:0]    sy_p0;
    logic            onscreen_p0, onscreen_p1;
    logic            vld_p1;
    logic [X_W:0]    px_p1;
    logic [Y_W:0]    py_p1;

    function automatic logic [BG_ADDR_W-1:0] bg_addr_of(input logic [X_W:0] x,
                                                        input logic [Y_W:0] y);
        return (BG_ADDR_W'(y) << 8) + (BG_ADDR_W'(y) << 6) + BG_ADDR_W'(x);
    endfunction

    assign start = (state == S_IDLE) && (drawBG || drawChar);
    assign scan  = (state == S_SCAN);

    pixel_scan_counter #(.SPRITE_W(SPRITE_W), .SPRITE_H(SPRITE_H)) u_scan (
        .clock  (clock),
        .resetn (resetn),
        .clear  (start),
        .enable (scan),
        .col    (col),
        .row    (row),
        .last   (last)
    );

    // Stage 0: pixel coordinate at full width so off-screen pixels never wrap
    assign sx_p0       = {1'b0, origin_x} + (X_W+1)'(col);
    assign sy_p0       = {1'b0, origin_y} + (Y_W+1)'(row);
    assign onscreen_p0 = (sx_p0 < (X_W+1)'(SCREEN_W)) && (sy_p0 < (Y_W+1)'(SCREEN_H));
    assign bg_addr     = (scan && onscreen_p0) ? bg_addr_of(sx_p0, sy_p0) : '0;
    assign spr_addr    = {row, col};

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state    <= S_IDLE;
            mode     <= MODE_BG;
            origin_x <= '0;
            origin_y <= '0;
            vld_p1   <= 1'b0;
            px_p1    <= '0;
            py_p1    <= '0;
        end else begin
            state  <= next_state;
            vld_p1 <= scan;
            px_p1  <= sx_p0;
            py_p1  <= sy_p0;
            if (start) begin
                origin_x <= xIn;
                origin_y <= yIn;
                mode     <= drawBG ? MODE_BG : MODE_CHAR;
            end
        end
    end

    // Stage 1: ROM data has returned for the pixel registered last cycle
    assign onscreen_p1 = (px_p1 < (X_W+1)'(SCREEN_W)) && (py_p1 < (Y_W+1)'(SCREEN_H));
    assign vga_x       = px_p1[X_W-1:0];
    assign vga_y       = py_p1[Y_W-1:0];
    assign vga_colour  = !vld_p1 ? '0 : (mode == MODE_BG) ? bg_data : spr_data;
    assign vga_plot    = vld_p1 && onscreen_p1 &&
                         ((mode == MODE_BG) || (spr_data != TRANSPARENT));

    always_comb begin
        next_state = state;
        doneBG     = 1'b0;
        doneChar   = 1'b0;
        busy       = (state != S_IDLE);
        case (state)
            S_IDLE:  if (drawBG || drawChar) next_state = S_SCAN;
            S_SCAN:  if (last) next_state = S_FLUSH;
            S_FLUSH: next_state = S_DONE;
            S_DONE: begin
                doneBG     = (mode == MODE_BG);
                doneChar   = (mode == MODE_CHAR);
                next_state = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_sprite_draw_engine.sv
// Directed bench for sprite_draw_engine: table of single-request boxes plus
// hand sequences for reset mid-scan, busy requests and back-to-back draws.
module tb_sprite_draw_engine;
    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        drawBG = 1'b0;
    logic        drawChar = 1'b0;
    logic [8:0]  xIn = '0;
    logic [7:0]  yIn = '0;
    logic [16:0] bg_addr;
    logic [2:0]  bg_data = '0;
    logic [5:0]  spr_addr;
    logic [2:0]  spr_data = '0;
    logic [8:0]  vga_x;
    logic [7:0]  vga_y;
    logic [2:0]  vga_colour;
    logic        vga_plot;
    logic        doneBG;
    logic        doneChar;
    logic        busy;

    sprite_draw_engine dut (
        .clock      (clock),
        .resetn     (resetn),
        .drawBG     (drawBG),
        .drawChar   (drawChar),
        .xIn        (xIn),
        .yIn        (yIn),
        .bg_addr    (bg_addr),
        .bg_data    (bg_data),
        .spr_addr   (spr_addr),
        .spr_data   (spr_data),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .vga_colour (vga_colour),
        .vga_plot   (vga_plot),
        .doneBG     (doneBG),
        .doneChar   (doneChar),
        .busy       (busy)
    );

    always #5 clock = ~clock;

    logic [2:0] spr_rom [64];

    function automatic logic [2:0] bg_fn(input int a);
        return 3'((a ^ (a >> 3) ^ (a >> 7)) & 7);
    endfunction

    // Synchronous ROM models, one cycle of latency
    always @(posedge clock) begin
        bg_data  <= bg_fn(int'(bg_addr));
        spr_data <= spr_rom[spr_addr];
    end

    typedef struct { int x; int y; int col; } pix_t;
    pix_t exp_q[$];

    typedef struct {
        logic b; logic c; int x; int y;
        int plots; int ndbg; int ndch; int addr0;
    } vec_t;
    vec_t vecs[4];

    int n_chk = 0;
    int n_err = 0;
    int n_plots, n_post_rst, n_bad, n_missing, n_off, n_idle;
    int dbg_cnt, dbg_first, dch_cnt, dch_first, addr0, busy1, busy_rst, plot_rst;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic add_box(input logic bg, input int x, input int y);
        pix_t p;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) begin
                p.x = x + c;
                p.y = y + r;
                if (p.x < 320 && p.y < 240) begin
                    if (bg) begin
                        p.col = int'(bg_fn(p.y * 320 + p.x));
                        exp_q.push_back(p);
                    end else if (spr_rom[r*8 + c] != 3'd0) begin
                        p.col = int'(spr_rom[r*8 + c]);
                        exp_q.push_back(p);
                    end
                end
            end
    endtask

    // Request 1 in cycle 0, optional request 2 in cycle c2cyc, optional reset in rstcyc
    task automatic run_case(input logic b1, input logic c1, input int x1, input int y1,
                            input int c2cyc, input logic b2, input logic c2,
                            input int x2, input int y2,
                            input int rstcyc, input int ncyc, input logic use_q);
        pix_t e;
        n_plots = 0; n_post_rst = 0; n_bad = 0; n_off = 0; n_idle = 0;
        dbg_cnt = 0; dbg_first = -1; dch_cnt = 0; dch_first = -1;
        addr0 = -1; busy1 = -1; busy_rst = -1; plot_rst = -1;
        @(negedge clock);
        drawBG = b1; drawChar = c1; xIn = 9'(x1); yIn = 8'(y1);
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge clock);
            drawBG = 1'b0; drawChar = 1'b0;
            if (c == c2cyc) begin
                drawBG = b2; drawChar = c2; xIn = 9'(x2); yIn = 8'(y2);
            end
            resetn = (c == rstcyc) ? 1'b0 : 1'b1;
            if (c == 1) begin
                addr0 = int'(bg_addr);
                busy1 = int'(busy);
            end
            if (c == rstcyc + 1) begin
                busy_rst = int'(busy);
                plot_rst = int'(vga_plot);
            end
            if (doneBG) begin
                dbg_cnt++;
                if (dbg_first < 0) dbg_first = c;
            end
            if (doneChar) begin
                dch_cnt++;
                if (dch_first < 0) dch_first = c;
            end
            if (vga_plot) begin
                n_plots++;
                if (rstcyc >= 0 && c > rstcyc) n_post_rst++;
                if (!busy) n_idle++;
                if (int'(vga_x) >= 320 || int'(vga_y) >= 240) n_off++;
                if (use_q) begin
                    if (exp_q.size() == 0) n_bad++;
                    else begin
                        e = exp_q.pop_front();
                        if (e.x != int'(vga_x) || e.y != int'(vga_y) || e.col != int'(vga_colour))
                            n_bad++;
                    end
                end
            end
        end
        drawBG = 1'b0; drawChar = 1'b0; resetn = 1'b1;
        n_missing = exp_q.size();
        exp_q.delete();
    endtask

    initial begin
        int tlist[10] = '{0, 5, 9, 18, 27, 36, 45, 54, 60, 63};
        for (int i = 0; i < 64; i++) spr_rom[i] = 3'((i % 7) + 1);
        for (int i = 0; i < 10; i++) spr_rom[tlist[i]] = 3'd0;

        vecs[0] = '{b:1'b1, c:1'b0, x:1,   y:16,  plots:64, ndbg:1, ndch:0, addr0:5121};
        vecs[1] = '{b:1'b0, c:1'b1, x:100, y:50,  plots:54, ndbg:0, ndch:1, addr0:16100};
        vecs[2] = '{b:1'b1, c:1'b0, x:316, y:236, plots:16, ndbg:1, ndch:0, addr0:75836};
        vecs[3] = '{b:1'b1, c:1'b1, x:40,  y:30,  plots:64, ndbg:1, ndch:0, addr0:9640};

        repeat (3) @(negedge clock);
        chk("reset busy", int'(busy), 0);
        chk("reset plot", int'(vga_plot), 0);
        chk("reset doneBG", int'(doneBG), 0);
        chk("reset doneChar", int'(doneChar), 0);
        chk("reset bg_addr", int'(bg_addr), 0);
        chk("reset spr_addr", int'(spr_addr), 0);
        chk("reset vga_xyc", int'(vga_x) + int'(vga_y) + int'(vga_colour), 0);
        resetn = 1'b1;
        @(negedge clock);

        for (int i = 0; i < 4; i++) begin
            add_box(vecs[i].b, vecs[i].x, vecs[i].y);
            run_case(vecs[i].b, vecs[i].c, vecs[i].x, vecs[i].y,
                     -1, 1'b0, 1'b0, 0, 0, -1, 80, 1'b1);
            chk($sformatf("v%0d busy c1", i), busy1, 1);
            chk($sformatf("v%0d first bg_addr", i), addr0, vecs[i].addr0);
            chk($sformatf("v%0d plots", i), n_plots, vecs[i].plots);
            chk($sformatf("v%0d pixel order/colour", i), n_bad + n_missing, 0);
            chk($sformatf("v%0d offscreen plots", i), n_off, 0);
            chk($sformatf("v%0d doneBG count", i), dbg_cnt, vecs[i].ndbg);
            chk($sformatf("v%0d doneChar count", i), dch_cnt, vecs[i].ndch);
            chk($sformatf("v%0d done cycle", i), (vecs[i].ndbg == 1) ? dbg_first : dch_first, 66);
        end

        // Reset in cycle 20 of a background scan
        run_case(1'b1, 1'b0, 1, 16, -1, 1'b0, 1'b0, 0, 0, 20, 80, 1'b0);
        chk("rst plots before", n_plots, 19);
        chk("rst plots after", n_post_rst, 0);
        chk("rst busy after", busy_rst, 0);
        chk("rst plot after", plot_rst, 0);
        chk("rst doneBG", dbg_cnt, 0);
        chk("rst doneChar", dch_cnt, 0);

        // drawChar at cycle 10 while busy must be ignored
        add_box(1'b1, 1, 16);
        run_case(1'b1, 1'b0, 1, 16, 10, 1'b0, 1'b1, 200, 100, -1, 80, 1'b1);
        chk("busy doneBG", dbg_cnt, 1);
        chk("busy doneBG cycle", dbg_first, 66);
        chk("busy doneChar", dch_cnt, 0);
        chk("busy plots", n_plots, 64);
        chk("busy pixel order", n_bad + n_missing, 0);

        // drawChar the cycle after doneBG is accepted
        add_box(1'b1, 1, 16);
        add_box(1'b0, 100, 50);
        run_case(1'b1, 1'b0, 1, 16, 67, 1'b0, 1'b1, 100, 50, -1, 140, 1'b1);
        chk("b2b doneBG cycle", dbg_first, 66);
        chk("b2b doneChar count", dch_cnt, 1);
        chk("b2b doneChar cycle", dch_first, 133);
        chk("b2b plots", n_plots, 118);
        chk("b2b pixel order", n_bad + n_missing, 0);
        chk("b2b idle plots", n_idle, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/sprite_draw_engine.md
Name: sprite_draw_engine

Overview:
- Downstream consumer of the sprite-movement FSM's xCoordinate, yCoordinate, drawBG and drawChar outputs.
- On each draw request it scans a SPRITE_W x SPRITE_H box anchored at the given origin.
- Per pixel it fetches colour from the background ROM (drawBG) or the character sprite ROM (drawChar) and emits plot writes to the 320x240 VGA adapter.
- It returns a one-cycle doneBG or doneChar pulse to the movement FSM when the box is finished.

Parameters:
- SPRITE_W, 8, sprite width in pixels (power of 2, 2..16).
- SPRITE_H, 8, sprite height in pixels (power of 2, 2..16).
- COLOUR_W, 3, colour bits per pixel.
- TRANSPARENT, 3'b000, sprite colour that is never plotted (character mode only).

Ports:
- clock  in  1  system clock.
- resetn  in  1  synchronous, active-low reset.
- drawBG  in  1  request: redraw background under box; sampled only in IDLE.
- drawChar  in  1  request: draw character sprite; sampled only in IDLE.
- xIn  in  9  box origin X (top-left).
- yIn  in  8  box origin Y (top-left).
- bg_addr  out  17  background ROM address, y*320+x.
- bg_data  in  COLOUR_W  background ROM data, 1-cycle synchronous latency.
- spr_addr  out  log2(W*H)  sprite ROM address, row*SPRITE_W+col.
- spr_data  in  COLOUR_W  sprite ROM data, 1-cycle latency.
- vga_x  out  9  plot X.
- vga_y  out  8  plot Y.
- vga_colour  out  COLOUR_W  plot colour.
- vga_plot  out  1  write strobe to VGA adapter.
- doneBG  out  1  one-cycle pulse, background box complete.
- doneChar  out  1  one-cycle pulse, character box complete.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset values:
  - state IDLE.
  - col, row, originX, originY, mode cleared to 0.
  - Pipeline valid bit cleared.
  - vga_plot=0, doneBG=0, doneChar=0, busy=0.
  - bg_addr=0, spr_addr=0.
  - vga_x, vga_y, vga_colour=0.
- States:
  - IDLE -> SCAN when drawBG|drawChar. On that edge: latch xIn/yIn into origin; latch mode (BG if drawBG, else CHAR); clear col and row. drawBG wins if both are high.
  - SCAN: issue addresses for (col,row) this cycle. col increments; at col=SPRITE_W-1 it wraps to 0 and row increments. After (W-1,H-1) -> FLUSH.
  - FLUSH: 1 cycle, so the last ROM word is plotted.
  - DONE: 1 cycle. Assert doneBG or doneChar per mode, then -> IDLE.
- Latency: with the request cycle counted as 0, the done pulse is high in cycle W*H+2 (66 for 8x8). The movement FSM's WAIT_BG/WAIT_CHAR states rely on this pulse.
- Pipeline:
  - Stage-1 register holds valid, px=originX+col and py=originY+row from the SCAN cycle.
  - vga_x, vga_y, vga_colour and vga_plot are driven in the cycle ROM data returns.
  - vga_colour = mode BG ? bg_data : spr_data.
- Plot strobe: vga_plot = valid & onscreen & (mode==BG | spr_data!=TRANSPARENT).
- Clipping:
  - onscreen = px<320 & py<240, computed at full width (10-bit X, 9-bit Y sum).
  - Off-screen pixels are never plotted and never wrap.
  - Their bg_addr is don't-care but must not exceed 76799; drive 0.
- bg_addr = (py<<8)+(py<<6)+px in 17 bits, combinational from the SCAN-cycle coordinates.
- Requests arriving while busy are ignored, not queued.
- Reset mid-operation: return to IDLE the next edge. No done pulse, vga_plot=0 from that edge.

Decomposition:
- Shared package (sprite_pkg):
  - SCREEN_W=320, SCREEN_H=240.
  - X_W=9, Y_W=8, BG_ADDR_W=17.
  - Draw-mode enum {MODE_BG, MODE_CHAR}.
  - Engine state encoding.
- One sub-module: pixel_scan_counter. It holds the col/row counters with wrap, inputs clear/enable, outputs col, row, last.

Test Plan:
- Reset mid-scan: drawBG at origin (1,16), assert resetn=0 at cycle 20 -> no done pulse, vga_plot=0 after the edge, busy=0, state IDLE.
- Background box: drawBG pulse, origin (1,16) ->
  - exactly 64 plots covering x 1..8, y 16..23 in raster order.
  - first bg_addr=16*320+1=5121.
  - doneBG high only in cycle 66; doneChar never high.
- Transparency: drawChar at (100,50), sprite ROM with 10 words = TRANSPARENT -> 54 plots; those 10 coordinates never plotted; doneChar pulse at cycle 66.
- Clipping: drawBG at origin (316,236) -> only 16 plots (x 316..319, y 236..239); no x>=320 or y>=240; doneBG still at cycle 66.
- Simultaneous and busy requests:
  - drawBG and drawChar high together -> BG mode is taken.
  - A second drawChar pulse at cycle 10 is ignored: exactly one doneBG, no doneChar.
- Back-to-back: drawBG, then drawChar issued the cycle after doneBG -> accepted; doneChar 66 cycles later; vga_plot never high during the IDLE gap.
